// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions for the SRAM responder.
//   RESP_OKAY / RESP_ERR : single-bit response encodings
//   rd_slv_state_t       : read-channel FSM states
//   wr_slv_state_t       : write-channel FSM states
package axi_lite_pkg;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } rd_slv_state_t;

  typedef enum logic [2:0] {
    W_IDLE,
    W_HAVE_A,
    W_HAVE_D,
    W_WAIT,
    W_RESP
  } wr_slv_state_t;

endpackage

// File: rtl/axi_lat_counter.sv
// 4-bit response-latency counter, one per AXI channel.
//   clk, reset : clock, synchronous active-high reset
//   load       : load load_val (takes priority over dec)
//   load_val   : number of wait cycles to count
//   dec        : count down by one (saturates at 0)
//   done       : the current wait cycle is the last one
module axi_lat_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       done
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)                   cnt <= 4'd0;
    else if (load)               cnt <= load_val;
    else if (dec && cnt != 4'd0) cnt <= cnt - 4'd1;
  end

  // A load of N gives exactly N wait cycles: the FSM leaves its wait
  // state on the cycle where one count remains.
  assign done = (cnt <= 4'd1);

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite responder backed by a word-organised SRAM with programmable
// read and write response latency. Read and write channels are independent;
// AW and W may arrive in either order or together.
//   clk, reset                       : clock, synchronous active-high reset
//   arvalid/arready/araddr           : read address channel
//   rvalid/rready/rdata/rresp        : read data channel
//   awvalid/awready/awaddr           : write address channel
//   wvalid/wready/wdata/wmask        : write data channel (wmask[3:0] used)
//   bvalid/bready/bresp              : write response channel
module axi_lite_sram_slave
  import axi_lite_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 10,
  parameter int          RD_DELAY   = 2,
  parameter int          WR_DELAY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic        rresp,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [7:0]  wmask,
  output logic        bvalid,
  input  logic        bready,
  output logic        bresp
);

  localparam int         DEPTH   = 1 << DEPTH_LOG2;
  localparam int         TAG_LSB = DEPTH_LOG2 + 2;
  localparam logic [3:0] RD_LAT  = 4'(RD_DELAY);
  localparam logic [3:0] WR_LAT  = 4'(WR_DELAY);

  logic [31:0] mem [DEPTH];

  // ---------------- read channel ----------------
  rd_slv_state_t           rd_state, rd_next;
  logic                    rd_load, rd_dec, rd_done, ar_cap, rd_sample;
  logic [31:0]             araddr_q, rd_addr, rdata_q;
  logic                    rresp_q, rd_hit;
  logic [DEPTH_LOG2-1:0]   rd_idx;

  assign ar_cap  = arready && arvalid;
  // With RD_DELAY=0 the SRAM is sampled on the AR handshake edge itself,
  // so the live address has to bypass the capture register.
  assign rd_addr = ar_cap ? araddr : araddr_q;
  assign rd_hit  = (rd_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign rd_idx  = rd_addr[TAG_LSB-1:2];

  always_comb begin
    rd_next = rd_state;
    rd_load = 1'b0;
    rd_dec  = 1'b0;
    case (rd_state)
      R_IDLE: if (ar_cap) begin
        rd_load = 1'b1;
        rd_next = (RD_DELAY == 0) ? R_RESP : R_WAIT;
      end
      R_WAIT: begin
        rd_dec = 1'b1;
        if (rd_done) rd_next = R_RESP;
      end
      R_RESP: if (rready) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  assign rd_sample = (rd_state != R_RESP) && (rd_next == R_RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state <= R_IDLE;
      araddr_q <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      rd_state <= rd_next;
      if (ar_cap) araddr_q <= araddr;
      if (rd_sample) begin
        rdata_q <= rd_hit ? mem[rd_idx] : '0;
        rresp_q <= rd_hit ? RESP_OKAY : RESP_ERR;
      end
    end
  end

  axi_lat_counter u_rd_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (rd_load),
    .load_val (RD_LAT),
    .dec      (rd_dec),
    .done     (rd_done)
  );

  // Handshake outputs are forced low combinationally while reset is held,
  // not just from the edge after it is sampled.
  assign arready = !reset && (rd_state == R_IDLE);
  assign rvalid  = !reset && (rd_state == R_RESP);
  assign rdata   = reset ? '0 : rdata_q;
  assign rresp   = reset ? RESP_OKAY : rresp_q;

  // ---------------- write channel ----------------
  wr_slv_state_t           wr_state, wr_next;
  logic                    wr_load, wr_dec, wr_done, aw_cap, w_cap;
  logic                    have_a, have_d, wr_commit, wr_hit, bresp_q;
  logic [31:0]             awaddr_q, wdata_q, wr_addr, wr_data;
  logic [3:0]              wbe_q, wr_be;
  logic [DEPTH_LOG2-1:0]   wr_idx;

  assign aw_cap  = awready && awvalid;
  assign w_cap   = wready && wvalid;
  assign wr_addr = aw_cap ? awaddr : awaddr_q;
  assign wr_data = w_cap ? wdata : wdata_q;
  assign wr_be   = w_cap ? wmask[3:0] : wbe_q;
  assign wr_hit  = (wr_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign wr_idx  = wr_addr[TAG_LSB-1:2];

  // "Holding" flags merge the stored half with whatever arrives this cycle,
  // so IDLE, HAVE_A and HAVE_D share one decision.
  assign have_a = aw_cap || (wr_state == W_HAVE_A);
  assign have_d = w_cap  || (wr_state == W_HAVE_D);

  always_comb begin
    wr_next = wr_state;
    wr_load = 1'b0;
    wr_dec  = 1'b0;
    case (wr_state)
      W_IDLE, W_HAVE_A, W_HAVE_D: begin
        if (have_a && have_d) begin
          wr_load = 1'b1;
          wr_next = (WR_DELAY == 0) ? W_RESP : W_WAIT;
        end else if (have_a) begin
          wr_next = W_HAVE_A;
        end else if (have_d) begin
          wr_next = W_HAVE_D;
        end
      end
      W_WAIT: begin
        wr_dec = 1'b1;
        if (wr_done) wr_next = W_RESP;
      end
      W_RESP: if (bready) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  assign wr_commit = !reset && (wr_state != W_RESP) && (wr_next == W_RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state <= W_IDLE;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wbe_q    <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      wr_state <= wr_next;
      if (aw_cap) awaddr_q <= awaddr;
      if (w_cap) begin
        wdata_q <= wdata;
        wbe_q   <= wmask[3:0];
      end
      if (wr_commit) bresp_q <= wr_hit ? RESP_OKAY : RESP_ERR;
    end
  end

  // SRAM contents survive reset. A same-edge read sample sees the old word
  // because both sides use nonblocking updates.
  always_ff @(posedge clk) begin
    if (wr_commit && wr_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  axi_lat_counter u_wr_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (wr_load),
    .load_val (WR_LAT),
    .dec      (wr_dec),
    .done     (wr_done)
  );

  assign awready = !reset && ((wr_state == W_IDLE) || (wr_state == W_HAVE_D));
  assign wready  = !reset && ((wr_state == W_IDLE) || (wr_state == W_HAVE_A));
  assign bvalid  = !reset && (wr_state == W_RESP);
  assign bresp   = reset ? RESP_OKAY : bresp_q;

  // Byte offset and upper mask bits carry no meaning for this memory.
  logic unused_bits;
  assign unused_bits = ^{rd_addr[1:0], wr_addr[1:0], wmask[7:4]};

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Scoreboard bench for axi_lite_sram_slave: stimulus pushes expected
// responses (payload and due cycle); a negedge monitor checks every cycle
// a response is presented and pops on handshake.
module tb_axi_lite_sram_slave;

  localparam int RD_DLY = 2;
  localparam int WR_DLY = 2;

  logic        clk = 1'b0, reset = 1'b1;
  logic        arvalid = 1'b0, rready = 1'b1, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic [7:0]  wmask = '0;
  logic        arready, rvalid, rresp, awready, wready, bvalid, bresp;
  logic [31:0] rdata;

  axi_lite_sram_slave #(
    .BASE_ADDR  (32'h8000_0000),
    .DEPTH_LOG2 (10),
    .RD_DELAY   (RD_DLY),
    .WR_DELAY   (WR_DLY)
  ) dut (
    .clk     (clk),     .reset   (reset),
    .arvalid (arvalid), .arready (arready), .araddr (araddr),
    .rvalid  (rvalid),  .rready  (rready),  .rdata  (rdata),  .rresp (rresp),
    .awvalid (awvalid), .awready (awready), .awaddr (awaddr),
    .wvalid  (wvalid),  .wready  (wready),  .wdata  (wdata),  .wmask (wmask),
    .bvalid  (bvalid),  .bready  (bready),  .bresp  (bresp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;

  typedef struct { logic [31:0] data; logic resp; int due; } rexp_t;
  typedef struct { logic resp; int due; } bexp_t;
  rexp_t rd_q[$];
  bexp_t wr_q[$];
  bit r_seen = 0, b_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (rvalid) begin
        chk("arready_low_during_rvalid", arready, 0);
        n_vec++;
        if (rd_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_rvalid: rvalid=1 at cycle %0d with no read outstanding", cyc);
        end else begin
          if (!r_seen) begin
            chk("rd_latency", cyc, rd_q[0].due);
            r_seen = 1;
          end
          chk("rdata", rdata, rd_q[0].data);
          chk("rresp", rresp, rd_q[0].resp);
          if (rready) begin
            void'(rd_q.pop_front());
            r_seen = 0;
          end
        end
      end
      if (bvalid) begin
        chk("awready_low_during_bvalid", awready, 0);
        chk("wready_low_during_bvalid", wready, 0);
        n_vec++;
        if (wr_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_bvalid: bvalid=1 at cycle %0d with no write outstanding", cyc);
        end else begin
          if (!b_seen) begin
            chk("wr_latency", cyc, wr_q[0].due);
            b_seen = 1;
          end
          chk("bresp", bresp, wr_q[0].resp);
          if (bready) begin
            void'(wr_q.pop_front());
            b_seen = 0;
          end
        end
      end
    end
  end

  // ---------------- handshake helpers ----------------
  task automatic hs_ar(input logic [31:0] a, output int k);
    araddr = a; arvalid = 1'b1; k = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (arready) begin k = cyc; break; end
    end
    @(posedge clk); #1 arvalid = 1'b0;
    n_vec++;
    if (k < 0) begin n_err++; $display("FAIL ar_handshake: arready never seen, expected within 40 cycles"); end
  endtask

  task automatic hs_aw(input logic [31:0] a, output int k);
    awaddr = a; awvalid = 1'b1; k = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (awready) begin k = cyc; break; end
    end
    @(posedge clk); #1 awvalid = 1'b0;
    n_vec++;
    if (k < 0) begin n_err++; $display("FAIL aw_handshake: awready never seen, expected within 40 cycles"); end
  endtask

  task automatic hs_w(input logic [31:0] d, input logic [7:0] m, output int k);
    wdata = d; wmask = m; wvalid = 1'b1; k = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (wready) begin k = cyc; break; end
    end
    @(posedge clk); #1 wvalid = 1'b0;
    n_vec++;
    if (k < 0) begin n_err++; $display("FAIL w_handshake: wready never seen, expected within 40 cycles"); end
  endtask

  task automatic hs_aww(input logic [31:0] a, input logic [31:0] d, input logic [7:0] m, output int k);
    awaddr = a; wdata = d; wmask = m; awvalid = 1'b1; wvalid = 1'b1; k = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (awready && wready) begin k = cyc; break; end
    end
    @(posedge clk); #1 begin awvalid = 1'b0; wvalid = 1'b0; end
    n_vec++;
    if (k < 0) begin n_err++; $display("FAIL aww_handshake: awready&wready never seen, expected within 40 cycles"); end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_r);
    int k;
    hs_ar(a, k);
    rd_q.push_back('{data: exp_d, resp: exp_r, due: k + RD_DLY + 1});
  endtask

  // mode 0: AW+W together; 1: W then AW 4 cycles later; 2: AW then W 2 cycles later
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [7:0] m,
                    input int mode, input logic exp_r);
    int ka, kw;
    ka = 0; kw = 0;
    if (mode == 0) begin
      hs_aww(a, d, m, ka);
      kw = ka;
    end else if (mode == 1) begin
      hs_w(d, m, kw);
      repeat (4) begin
        @(negedge clk);
        chk("awready_while_have_d", awready, 1);
        chk("wready_while_have_d", wready, 0);
        @(posedge clk); #1;
      end
      hs_aw(a, ka);
    end else begin
      hs_aw(a, ka);
      repeat (2) begin
        @(negedge clk);
        chk("wready_while_have_a", wready, 1);
        chk("awready_while_have_a", awready, 0);
        @(posedge clk); #1;
      end
      hs_w(d, m, kw);
    end
    wr_q.push_back('{resp: exp_r, due: ((ka > kw) ? ka : kw) + WR_DLY + 1});
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((rd_q.size() != 0 || wr_q.size() != 0) && i < 100) begin
      @(posedge clk); i++;
    end
    n_vec++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d reads and %0d writes outstanding, expected 0", rd_q.size(), wr_q.size());
      rd_q.delete(); wr_q.delete(); r_seen = 0; b_seen = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_idle_after_reset(input string tag);
    chk({tag, "_arready"}, arready, 1);
    chk({tag, "_awready"}, awready, 1);
    chk({tag, "_wready"}, wready, 1);
    chk({tag, "_rvalid"}, rvalid, 0);
    chk({tag, "_bvalid"}, bvalid, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", arready, 0); chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);   chk("rst_rvalid", rvalid, 0);
    chk("rst_bvalid", bvalid, 0);   chk("rst_rdata", rdata, 0);
    chk("rst_rresp", rresp, 0);     chk("rst_bresp", bresp, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_idle_after_reset("post_rst");
    @(posedge clk); #1;

    // AW+W together, then read back
    wr(32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 0, 1'b0); drain();
    rd(32'h8000_0010, 32'hDEAD_BEEF, 1'b0); drain();

    // W first, AW later, partial byte mask
    wr(32'h8000_0010, 32'h1122_3344, 8'h05, 1, 1'b0); drain();
    rd(32'h8000_0010, 32'hDE22_BE44, 1'b0); drain();

    // Out of range (word 1023 seeded; wmask[7:4] must be ignored)
    wr(32'h8000_0FFC, 32'h0BAD_F00D, 8'hFF, 2, 1'b0); drain();
    wr(32'h7FFF_FFFC, 32'hCAFE_F00D, 8'h0F, 0, 1'b1); drain();
    rd(32'h9000_0000, 32'h0000_0000, 1'b1); drain();
    rd(32'h8000_0FFC, 32'h0BAD_F00D, 1'b0); drain();

    // Backpressure: hold rready/bready low for 5 cycles once both are valid
    rready = 1'b0; bready = 1'b0;
    fork
      rd(32'h8000_0010, 32'hDE22_BE44, 1'b0);
      wr(32'h8000_0030, 32'h55AA_55AA, 8'h0F, 2, 1'b0);
    join
    for (int i = 0; i < 40 && !(rvalid && bvalid); i++) @(negedge clk);
    chk("bp_both_valid", {30'd0, rvalid, bvalid}, 32'd3);
    repeat (5) @(posedge clk);
    #1 begin rready = 1'b1; bready = 1'b1; end
    drain();
    rd(32'h8000_0030, 32'h55AA_55AA, 1'b0); drain();

    // Read sample and write commit on the same edge: read-first
    wr(32'h8000_0020, 32'h0000_0001, 8'h0F, 0, 1'b0); drain();
    fork
      rd(32'h8000_0020, 32'h0000_0001, 1'b0);
      wr(32'h8000_0020, 32'h0000_0002, 8'h0F, 0, 1'b0);
    join
    drain();
    rd(32'h8000_0020, 32'h0000_0002, 1'b0); drain();

    // Reset during R_WAIT and W_HAVE_A: both transactions dropped
    wr(32'h8000_0040, 32'h1234_5678, 8'h0F, 0, 1'b0); drain();
    hs_ar(32'h8000_0040, k);
    hs_aw(32'h8000_0040, k);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_arready", arready, 0); chk("mid_rst_awready", awready, 0);
    chk("mid_rst_wready", wready, 0);   chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_bvalid", bvalid, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_idle_after_reset("after_mid_rst");
    repeat (10) @(posedge clk);
    #1;
    // A lone W after reset must pair with a fresh AW, not the dropped one
    wr(32'h8000_0044, 32'hBBBB_BBBB, 8'h0F, 1, 1'b0); drain();
    rd(32'h8000_0040, 32'h1234_5678, 1'b0); drain();
    rd(32'h8000_0044, 32'hBBBB_BBBB, 1'b0); drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500us, expected completion");
    $fatal(1);
  end

endmodule
